score_argmax: RTL and testbench

//  Downstream stage of VectorMatrixProduct. Captures the packed vector of per-class

---
 rtl/score_argmax.sv | 150 +++++++++++++++
 tb/tb_score_argmax.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/score_argmax.sv
// Serial argmax over a captured vector of signed Q8.18 class scores.
// Reports the winning index, its score and the margin over the runner-up.
module score_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 26,
    parameter int IDX_W       = 4
) (
    input  logic                           clk,
    input  logic                           GlobalReset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               class_idx,
    output logic [SCORE_W-1:0]             best_score,
    output logic [SCORE_W:0]               margin,
    output logic                           busy
);

    // Handshake: a vector transfers on an edge where in_valid && in_ready; a
    // result transfers on an edge where out_valid && out_ready. out_valid and
    // the result outputs stay stable until that transfer.

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    state_t                           state_q, state_d;
    logic [NUM_CLASSES*SCORE_W-1:0]   vec_q, vec_d;
    logic signed [SCORE_W-1:0]        best_q, best_d;
    logic signed [SCORE_W-1:0]        second_q, second_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [IDX_W-1:0]                 cnt_q, cnt_d;
    logic [IDX_W-1:0]                 class_idx_q, class_idx_d;
    logic [SCORE_W-1:0]               best_score_q, best_score_d;
    logic [SCORE_W:0]                 margin_q, margin_d;

    logic signed [SCORE_W-1:0]        cur_score;
    logic signed [SCORE_W-1:0]        cand_best;
    logic signed [SCORE_W-1:0]        cand_second;
    logic [IDX_W-1:0]                 cand_idx;
    logic signed [SCORE_W-1:0]        first_score;

    // Widened by one bit so max - min cannot overflow.
    function automatic logic [SCORE_W:0] diff_ext(input logic signed [SCORE_W-1:0] a,
                                                  input logic signed [SCORE_W-1:0] b);
        return {a[SCORE_W-1], a} - {b[SCORE_W-1], b};
    endfunction

    always_comb begin
        cur_score   = $signed(vec_q[int'(cnt_q)*SCORE_W +: SCORE_W]);
        first_score = $signed(scores[SCORE_W-1:0]);
        cand_best   = best_q;
        cand_second = second_q;
        cand_idx    = idx_q;
        // Strict compare keeps the lowest index on ties.
        if (cur_score > best_q) begin
            cand_second = best_q;
            cand_best   = cur_score;
            cand_idx    = cnt_q;
        end else if (cur_score > second_q) begin
            cand_second = cur_score;
        end
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        best_d       = best_q;
        second_d     = second_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        class_idx_d  = class_idx_q;
        best_score_d = best_score_q;
        margin_d     = margin_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d    = scores;
                    best_d   = first_score;
                    second_d = MIN_SCORE;
                    idx_d    = '0;
                    cnt_d    = IDX_W'(1);
                    if (NUM_CLASSES == 1) begin
                        state_d      = S_DONE;
                        class_idx_d  = '0;
                        best_score_d = first_score;
                        margin_d     = diff_ext(first_score, MIN_SCORE);
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                best_d   = cand_best;
                second_d = cand_second;
                idx_d    = cand_idx;
                if (cnt_q == LAST_IDX) begin
                    state_d      = S_DONE;
                    class_idx_d  = cand_idx;
                    best_score_d = cand_best;
                    margin_d     = diff_ext(cand_best, cand_second);
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            best_q       <= '0;
            second_q     <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            class_idx_q  <= '0;
            best_score_q <= '0;
            margin_q     <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            best_q       <= best_d;
            second_q     <= second_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            class_idx_q  <= class_idx_d;
            best_score_q <= best_score_d;
            margin_q     <= margin_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign class_idx  = class_idx_q;
    assign best_score = best_score_q;
    assign margin     = margin_q;

endmodule

// File: tb/tb_score_argmax.sv
// Directed bench for score_argmax: a vector table plus hand-written
// backpressure and mid-scan reset sequences.
module tb_score_argmax;

    localparam int N  = 10;
    localparam int SW = 26;
    localparam int IW = 4;

    typedef struct {
        string           name;
        logic [N*SW-1:0] vec;
        logic [IW-1:0]   idx;
        logic [SW-1:0]   best;
        logic [SW:0]     margin;
    } vec_t;

    logic            clk = 1'b0;
    logic            GlobalReset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*SW-1:0] scores = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IW-1:0]   class_idx;
    logic [SW-1:0]   best_score;
    logic [SW:0]     margin;
    logic            busy;

    int total = 0;
    int bad   = 0;

    vec_t tbl[7];

    score_argmax #(.NUM_CLASSES(N), .SCORE_W(SW), .IDX_W(IW)) dut (
        .clk(clk), .GlobalReset(GlobalReset),
        .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
        .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .best_score(best_score), .margin(margin),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*SW-1:0] fill(input int v);
        logic [N*SW-1:0] r;
        for (int k = 0; k < N; k++) r[k*SW +: SW] = SW'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        GlobalReset = 1'b0;
        tick();
        tick();
        GlobalReset = 1'b1;
    endtask

    // Returns once the vector has been accepted on an edge.
    task automatic send(input logic [N*SW-1:0] v);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        scores   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scores   = fill(32'h155);
    endtask

    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        check({name, "_latency"}, 64'(cycles), 64'(N - 1));
    endtask

    task automatic run_vector(input vec_t t);
        int cyc;
        send(t.vec);
        wait_done(t.name, cyc);
        check({t.name, "_idx"}, 64'(class_idx), 64'(t.idx));
        check({t.name, "_best"}, 64'(best_score), 64'(t.best));
        check({t.name, "_margin"}, 64'(margin), 64'(t.margin));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({t.name, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({t.name, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({t.name, "_hold_idx"}, 64'(class_idx), 64'(t.idx));
    endtask

    initial begin
        int cyc;
        logic [IW-1:0] h_idx;
        logic [SW-1:0] h_best;
        logic [SW:0]   h_margin;

        // Test 1: all +1.0, lowest index wins, margin 0.
        tbl[0].name = "all_equal";
        tbl[0].vec  = fill(32'h40000);
        tbl[0].idx  = 4'd0; tbl[0].best = 26'h40000; tbl[0].margin = 27'h0;
        // Test 2: ramp.
        tbl[1].name = "ramp";
        for (int k = 0; k < N; k++) tbl[1].vec[k*SW +: SW] = SW'(k * 32'h40000);
        tbl[1].idx  = 4'd9; tbl[1].best = 26'h240000; tbl[1].margin = 27'h40000;
        // Test 3: all negative.
        tbl[2].name = "all_neg";
        tbl[2].vec  = fill(-32'sh80000);
        tbl[2].vec[3*SW +: SW] = SW'(-32'sh8000);
        tbl[2].idx  = 4'd3; tbl[2].best = SW'(-32'sh8000); tbl[2].margin = 27'h78000;
        // Test 4: extremes against zero.
        tbl[3].name = "max_min";
        tbl[3].vec  = fill(0);
        tbl[3].vec[7*SW +: SW] = 26'h1FFFFFF;
        tbl[3].vec[2*SW +: SW] = 26'h2000000;
        tbl[3].idx  = 4'd7; tbl[3].best = 26'h1FFFFFF; tbl[3].margin = 27'h1FFFFFF;
        // Max against all-min: widest margin.
        tbl[4].name = "widest";
        tbl[4].vec  = fill(32'h2000000);
        tbl[4].vec[0 +: SW] = 26'h1FFFFFF;
        tbl[4].idx  = 4'd0; tbl[4].best = 26'h1FFFFFF; tbl[4].margin = 27'h3FFFFFF;
        // Tie at 5 and 8 above the rest.
        tbl[5].name = "tie_mid";
        tbl[5].vec  = fill(32'h100);
        tbl[5].vec[5*SW +: SW] = 26'h3000;
        tbl[5].vec[8*SW +: SW] = 26'h3000;
        tbl[5].idx  = 4'd5; tbl[5].best = 26'h3000; tbl[5].margin = 27'h0;
        // Runner-up found after the winner.
        tbl[6].name = "late_second";
        tbl[6].vec  = fill(0);
        tbl[6].vec[0*SW +: SW] = 26'h100;
        tbl[6].vec[1*SW +: SW] = 26'h10;
        tbl[6].vec[2*SW +: SW] = 26'h80;
        tbl[6].idx  = 4'd0; tbl[6].best = 26'h100; tbl[6].margin = 27'h80;

        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_idx", 64'(class_idx), 64'd0);
        check("rst_best", 64'(best_score), 64'd0);
        check("rst_margin", 64'(margin), 64'd0);

        for (int i = 0; i < 7; i++) run_vector(tbl[i]);

        // Backpressure: result held, input ignored while DONE.
        send(tbl[1].vec);
        check("bp_busy_scan", 64'(busy), 64'd1);
        wait_done("bp", cyc);
        h_idx = class_idx; h_best = best_score; h_margin = margin;
        check("bp_idx", 64'(h_idx), 64'd9);
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            scores   = tbl[3].vec;
            tick();
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_outputs_hold", {class_idx, best_score, margin}, {h_idx, h_best, h_margin});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_busy", 64'(busy), 64'd0);
        check("bp_idle_hold", {class_idx, best_score, margin}, {h_idx, h_best, h_margin});

        // Reset in SCAN cycle 4 aborts, with a stray in_valid during the scan.
        send(tbl[3].vec);
        in_valid = 1'b1;
        scores   = tbl[0].vec;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        GlobalReset = 1'b0;
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_outputs", {class_idx, best_score, margin}, 64'd0);
        GlobalReset = 1'b1;
        run_vector(tbl[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

endmodule
